// File: rtl/lcd_pkg.sv
// Shared types and field positions for the HD44780 write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  // io_lcd field positions (CPU-written word)
  localparam int IO_ON_BIT      = 31;
  localparam int IO_BLON_BIT    = 30;
  localparam int IO_CLR_OVR_BIT = 11;
  localparam int IO_GO_BIT      = 10;
  localparam int IO_RS_BIT      = 9;
  localparam int IO_DATA_LSB    = 0;
  localparam int IO_DATA_MSB    = 7;

  // lcd_status field positions (CPU-readable word)
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_PEND_BIT  = 1;
  localparam int ST_OVR_BIT   = 2;
  localparam int ST_LAST_LSB  = 8;
  localparam int ST_LAST_MSB  = 15;
  localparam int ST_CNT_LSB   = 16;
  localparam int ST_CNT_MSB   = 31;

  // Largest of the five timing parameters; sizes the shared delay counter.
  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Board-side HD44780 pin bundle; the controller drives it, the panel listens.
interface lcd_hd44780_ctrl_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic       lcd_blon;

  modport master (
    output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon
  );

  modport slave (
    input lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon
  );
endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that holds at zero; the FSM reloads it on every
// state entry and watches the zero flag to leave the state.
module lcd_delay_cnt #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-cycle engine driven by the CPU io_lcd word. Each GO toggle
// runs setup / EN pulse / hold / execution wait; one extra request may be
// queued while busy, further ones set a sticky overrun flag.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int CLR_CYC   = 80000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            io_lcd,
  lcd_hd44780_ctrl_if.master     pins,
  output logic [31:0]            lcd_status
);

  localparam int MAX_CYC = max_cyc(SETUP_CYC, EN_CYC, HOLD_CYC, EXEC_CYC, CLR_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_CYC - 1);

  lcd_state_e  state_q, state_d;
  logic        go_prev_q, go_prev_d;
  logic        shadow_rs_q, shadow_rs_d;
  logic [7:0]  shadow_data_q, shadow_data_d;
  logic        pend_rs_q, pend_rs_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        pending_q, pending_d;
  logic        ovr_q, ovr_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  last_q, last_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        on_q, on_d;
  logic        blon_q, blon_d;

  logic             req_s;
  logic             req_rs_s;
  logic [7:0]       req_data_s;
  logic             direct_s;
  logic             consume_s;
  logic             ovr_set_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_zero_s;
  logic             unused_io_s;

  assign req_s       = (io_lcd[IO_GO_BIT] != go_prev_q);
  assign req_rs_s    = io_lcd[IO_RS_BIT];
  assign req_data_s  = io_lcd[IO_DATA_MSB:IO_DATA_LSB];
  assign unused_io_s = ^{io_lcd[29:12], io_lcd[8]};

  lcd_delay_cnt #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, counter loads, shadow/pending bookkeeping and status updates.
  always_comb begin
    state_d       = state_q;
    go_prev_d     = io_lcd[IO_GO_BIT];
    shadow_rs_d   = shadow_rs_q;
    shadow_data_d = shadow_data_q;
    pend_rs_d     = pend_rs_q;
    pend_data_d   = pend_data_q;
    pending_d     = pending_q;
    count_d       = count_q;
    last_d        = last_q;
    cnt_load_s    = 1'b0;
    cnt_val_s     = {CNT_W{1'b0}};
    direct_s      = 1'b0;
    consume_s     = 1'b0;
    ovr_set_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        direct_s = 1'b1;
        if (req_s) begin
          shadow_rs_d   = req_rs_s;
          shadow_data_d = req_data_s;
          state_d       = ST_SETUP;
          cnt_load_s    = 1'b1;
          cnt_val_s     = LD_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_zero_s) begin
          state_d    = ST_PULSE;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_EN;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          state_d    = ST_HOLD;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_HOLD;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (cnt_zero_s) begin
          state_d    = ST_WAIT;
          cnt_load_s = 1'b1;
          cnt_val_s  = is_slow_cmd(shadow_rs_q, shadow_data_q) ? LD_CLR : LD_EXEC;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (cnt_zero_s) begin
          count_d = count_q + 16'd1;
          last_d  = shadow_data_q;
          if (pending_q) begin
            // Queued word goes straight to SETUP, no idle gap.
            consume_s     = 1'b1;
            pending_d     = 1'b0;
            shadow_rs_d   = pend_rs_q;
            shadow_data_d = pend_data_q;
            state_d       = ST_SETUP;
            cnt_load_s    = 1'b1;
            cnt_val_s     = LD_SETUP;
          end else if (req_s) begin
            // A request landing on the completing edge is taken as if idle.
            direct_s      = 1'b1;
            shadow_rs_d   = req_rs_s;
            shadow_data_d = req_data_s;
            state_d       = ST_SETUP;
            cnt_load_s    = 1'b1;
            cnt_val_s     = LD_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests the FSM did not take directly go to the single pending slot;
    // a slot being drained on this edge can be refilled at once.
    if (req_s && !direct_s) begin
      if (!pending_q || consume_s) begin
        pending_d   = 1'b1;
        pend_rs_d   = req_rs_s;
        pend_data_d = req_data_s;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else begin
      ovr_set_s = 1'b0;
    end

    // Overrun is sticky; a new overrun beats a concurrent clear.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (io_lcd[IO_CLR_OVR_BIT]) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    en_d   = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE) || pending_d;
    on_d   = io_lcd[IO_ON_BIT];
    blon_d = io_lcd[IO_BLON_BIT];
  end

  // State and output registers; async reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      go_prev_q     <= 1'b0;
      shadow_rs_q   <= 1'b0;
      shadow_data_q <= 8'd0;
      pend_rs_q     <= 1'b0;
      pend_data_q   <= 8'd0;
      pending_q     <= 1'b0;
      ovr_q         <= 1'b0;
      count_q       <= 16'd0;
      last_q        <= 8'd0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      on_q          <= 1'b0;
      blon_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      go_prev_q     <= go_prev_d;
      shadow_rs_q   <= shadow_rs_d;
      shadow_data_q <= shadow_data_d;
      pend_rs_q     <= pend_rs_d;
      pend_data_q   <= pend_data_d;
      pending_q     <= pending_d;
      ovr_q         <= ovr_d;
      count_q       <= count_d;
      last_q        <= last_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      on_q          <= on_d;
      blon_q        <= blon_d;
    end
  end

  assign pins.lcd_data = shadow_data_q;
  assign pins.lcd_rs   = shadow_rs_q;
  assign pins.lcd_rw   = 1'b0;
  assign pins.lcd_en   = en_q;
  assign pins.lcd_on   = on_q;
  assign pins.lcd_blon = blon_q;

  assign lcd_status[ST_BUSY_BIT]             = busy_q;
  assign lcd_status[ST_PEND_BIT]             = pending_q;
  assign lcd_status[ST_OVR_BIT]              = ovr_q;
  assign lcd_status[7:3]                     = 5'd0;
  assign lcd_status[ST_LAST_MSB:ST_LAST_LSB] = last_q;
  assign lcd_status[ST_CNT_MSB:ST_CNT_LSB]   = count_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: stimulus queues expected transfers, a negedge monitor
// checks each EN strobe, its setup, width and the following wait.
module tb_lcd_hd44780_ctrl;

  localparam int SETUP = 2;
  localparam int EN    = 3;
  localparam int HOLD  = 1;
  localparam int EXEC  = 5;
  localparam int CLR   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_lcd = 32'd0;
  logic [31:0] lcd_status;

  lcd_hd44780_ctrl_if pins ();

  lcd_hd44780_ctrl #(
    .SETUP_CYC (SETUP),
    .EN_CYC    (EN),
    .HOLD_CYC  (HOLD),
    .EXEC_CYC  (EXEC),
    .CLR_CYC   (CLR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_lcd     (io_lcd),
    .pins       (pins),
    .lcd_status (lcd_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_len;
    bit         b2b;
  } xfer_t;

  xfer_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  logic [15:0] exp_count = 16'd0;
  logic [7:0]  exp_last  = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic go(input logic rs, input logic [7:0] data, input int wait_len,
                    input bit b2b, input bit push);
    xfer_t x;
    @(negedge clk);
    io_lcd[9]   = rs;
    io_lcd[7:0] = data;
    io_lcd[10]  = ~io_lcd[10];
    if (push) begin
      x.rs = rs; x.data = data; x.wait_len = wait_len; x.b2b = b2b;
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!lcd_status[0]) done = 1'b1;
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_en(input logic level, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (pins.lcd_en == level) done = 1'b1;
    end
    check("en_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic check_status(input string name, input bit busy, input bit pend, input bit ovr);
    check(name, lcd_status, {exp_count, exp_last, 5'd0, ovr, pend, busy});
    check("lcd_rw", {31'd0, pins.lcd_rw}, 32'd0);
  endtask

  // Monitor: pops an expected transfer on every EN rising edge.
  initial begin : monitor
    xfer_t      cur;
    bit         have_cur;
    logic       en_prev, busy_prev, en, busy;
    logic [8:0] pins_now, prev_pins, rise_pins;
    int         stable, width, gap;
    have_cur = 1'b0; en_prev = 1'b0; busy_prev = 1'b0;
    prev_pins = 9'd0; rise_pins = 9'd0; stable = 0; width = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur = 1'b0; en_prev = 1'b0; busy_prev = 1'b0;
        stable = 0; width = 0; gap = 0; prev_pins = 9'd0;
      end else begin
        en       = pins.lcd_en;
        busy     = lcd_status[0];
        pins_now = {pins.lcd_rs, pins.lcd_data};
        if (!busy) begin
          stable = 0;
        end else if (!en) begin
          if (busy_prev && !en_prev && pins_now == prev_pins) stable++;
          else stable = 1;
        end
        if (en && !en_prev) begin
          if (have_cur) begin
            check("b2b_expected", {31'd0, cur.b2b}, 32'd1);
            check("b2b_gap", gap, HOLD + cur.wait_len + SETUP);
          end
          if (exp_q.size() == 0) begin
            check("unexpected_en", 32'd1, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check("rs_at_en", {31'd0, pins.lcd_rs}, {31'd0, cur.rs});
            check("data_at_en", {24'd0, pins.lcd_data}, {24'd0, cur.data});
            check("setup_len", stable, SETUP);
          end
          rise_pins = pins_now;
          width = 1;
          gap = 0;
        end else if (en) begin
          width++;
        end else if (en_prev) begin
          check("en_width", width, EN);
          check("pins_stable_en", {23'd0, pins_now}, {23'd0, rise_pins});
          gap = 1;
        end else if (busy && have_cur && gap > 0) begin
          gap++;
        end
        if (!busy && busy_prev && have_cur) begin
          check("b2b_expected", {31'd0, cur.b2b}, 32'd0);
          check("wait_gap", gap, HOLD + cur.wait_len);
          have_cur = 1'b0;
        end
        en_prev   = en;
        busy_prev = busy;
        prev_pins = pins_now;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", lcd_status, 32'd0);
    check("rst_en", {31'd0, pins.lcd_en}, 32'd0);
    check("rst_data", {23'd0, pins.lcd_rs, pins.lcd_data}, 32'd0);
    check("rst_on", {30'd0, pins.lcd_on, pins.lcd_blon}, 32'd0);
    rst = 1'b1;

    // Power / backlight follow with one cycle latency
    @(negedge clk);
    io_lcd[31] = 1'b1;
    io_lcd[30] = 1'b0;
    @(negedge clk);
    check("on_blon", {30'd0, pins.lcd_on, pins.lcd_blon}, 32'd2);

    // Single data write
    go(1'b1, 8'h41, EXEC, 1'b0, 1'b1);
    wait_idle(100);
    exp_count = 16'd1; exp_last = 8'h41;
    check_status("status_0x41", 1'b0, 1'b0, 1'b0);
    check("pins_idle", {23'd0, pins.lcd_rs, pins.lcd_data}, {23'd0, 1'b1, 8'h41});

    // Clear/home vs normal command waits
    go(1'b0, 8'h01, CLR, 1'b0, 1'b1);  wait_idle(100);
    go(1'b0, 8'h80, EXEC, 1'b0, 1'b1); wait_idle(100);
    go(1'b0, 8'h03, CLR, 1'b0, 1'b1);  wait_idle(100);
    go(1'b1, 8'h01, EXEC, 1'b0, 1'b1); wait_idle(100);
    exp_count = 16'd5; exp_last = 8'h01;
    check_status("status_cmds", 1'b0, 1'b0, 1'b0);

    // Pending + overrun: two toggles during PULSE
    go(1'b1, 8'h30, EXEC, 1'b1, 1'b1);
    wait_en(1'b1, 20);
    go(1'b1, 8'h31, EXEC, 1'b0, 1'b1);
    go(1'b1, 8'h32, EXEC, 1'b0, 1'b0);
    @(negedge clk);
    check_status("status_pend_ovr", 1'b1, 1'b1, 1'b1);
    wait_idle(200);
    exp_count = 16'd7; exp_last = 8'h31;
    check_status("status_after_b2b", 1'b0, 1'b0, 1'b1);
    io_lcd[11] = 1'b1;
    @(negedge clk);
    io_lcd[11] = 1'b0;
    check_status("status_ovr_clr", 1'b0, 1'b0, 1'b0);

    // Request on the exact edge WAIT expires
    go(1'b1, 8'h52, EXEC, 1'b1, 1'b1);
    wait_en(1'b1, 20);
    wait_en(1'b0, 20);
    repeat (HOLD + EXEC - 2) @(negedge clk);
    go(1'b1, 8'h53, EXEC, 1'b0, 1'b1);
    wait_idle(200);
    exp_count = 16'd9; exp_last = 8'h53;
    check_status("status_expiry", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the EN pulse
    go(1'b1, 8'h60, EXEC, 1'b0, 1'b1);
    wait_en(1'b1, 20);
    #2;
    rst = 1'b0;
    io_lcd[10] = 1'b0;
    #1;
    check("rst_mid_en", {31'd0, pins.lcd_en}, 32'd0);
    check("rst_mid_status", lcd_status, 32'd0);
    check("rst_mid_pins", {23'd0, pins.lcd_rs, pins.lcd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_count = 16'd0; exp_last = 8'h00;
    go(1'b1, 8'h61, EXEC, 1'b0, 1'b1);
    wait_idle(100);
    exp_count = 16'd1; exp_last = 8'h61;
    check_status("status_after_rst", 1'b0, 1'b0, 1'b0);

    // Count wrap
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    check_status("status_preload", 1'b0, 1'b0, 1'b0);
    go(1'b0, 8'h80, EXEC, 1'b0, 1'b1);
    wait_idle(100);
    exp_count = 16'h0000; exp_last = 8'h80;
    check_status("status_wrap", 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Peripheral-side consumer of the CPU's `io_lcd` output register.
- Decodes the word that software writes and runs the HD44780 write cycle: setup, EN pulse, hold, then the command execution wait.
- Software no longer bit-bangs EN or counts delays; it polls a status word.
- Sits between the LSU output buffer and the board LCD pins.

Parameters:
- `SETUP_CYC`, default 2: cycles RS/DATA stable before EN rises (tAS).
- `EN_CYC`, default 12: cycles EN held high (PWEH ≥ 230 ns at 50 MHz).
- `HOLD_CYC`, default 2: cycles RS/DATA held after EN falls (tH).
- `EXEC_CYC`, default 2000: post-write wait for normal commands and data (≥ 37 µs).
- `CLR_CYC`, default 80000: post-write wait for clear/home (≥ 1.52 ms).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `io_lcd`, in, 32: CPU word.
  - [31] ON
  - [30] BLON
  - [11] CLR_OVR (level)
  - [10] GO toggle
  - [9] RS
  - [7:0] DATA
- `lcd_data`, out, 8: LCD DB7..DB0.
- `lcd_rs`, out, 1: register select.
- `lcd_rw`, out, 1: read/write; tied 0, write-only controller.
- `lcd_en`, out, 1: enable strobe.
- `lcd_on`, out, 1: LCD power.
- `lcd_blon`, out, 1: backlight.
- `lcd_status`, out, 32: CPU-readable status.
  - [0] busy
  - [1] pending
  - [2] overrun
  - [15:8] last DATA sent
  - [31:16] completed-transfer count

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, `go_prev`=0, pending=0, overrun=0, count=0.
  - Reset mid-transfer drops `lcd_en` immediately; the transfer is abandoned and not counted.
- Request detect: a request exists on a clock edge where `io_lcd[10] != go_prev`; `go_prev` updates every cycle.
  - The first edge after reset with [10]=1 is a request.
- `lcd_on`/`lcd_blon` are registered copies of [31]/[30], 1-cycle latency, independent of the FSM.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. A single down-counter is loaded on each state entry.
- IDLE, on request: latch RS and DATA into the shadow register, drive `lcd_rs`/`lcd_data` from the shadow, `lcd_en`=0, load SETUP_CYC-1, go to SETUP.
- SETUP: when counter=0, set `lcd_en`=1, load EN_CYC-1, go to PULSE.
- PULSE: when counter=0, set `lcd_en`=0, load HOLD_CYC-1, go to HOLD.
  - `lcd_en` is high for exactly EN_CYC consecutive cycles.
- HOLD: when counter=0, go to WAIT and load the wait time:
  - CLR_CYC-1 if RS=0 and DATA[7:2]=0 and DATA≠0 (clear/home).
  - EXEC_CYC-1 otherwise.
- WAIT: when counter=0, increment count (16-bit, wraps 0xFFFF→0) and set status[15:8]=DATA.
  - If pending=1: clear pending, load the pending word into the shadow, go directly to SETUP (no IDLE cycle).
  - Otherwise go to IDLE.
- `lcd_rs`/`lcd_data` change only on IDLE→SETUP or WAIT→SETUP entry; they are stable through SETUP, PULSE and HOLD.
- Request in any non-IDLE state:
  - If pending=0: set pending=1 and latch RS/DATA into the pending register.
  - If pending=1: drop the request and set overrun (sticky).
- Request in the same edge that WAIT completes with pending=0: treated as an IDLE request. The FSM goes straight to SETUP with the new word.
- CLR_OVR: while [11]=1, overrun is cleared. If set and clear occur in the same cycle, set wins.
- busy = (state ≠ IDLE) OR pending; registered, consistent with state.
- ON=0 does not block transfers; it only drives the pin.

Decomposition:
- `lcd_pkg`: state enum `lcd_state_e`; bit-position constants for `io_lcd` fields (ON, BLON, CLR_OVR, GO, RS, DATA LSB/MSB); bit positions for `lcd_status` fields.
- Sub-module `lcd_delay_cnt`:
  - Loadable down-counter of width $clog2(max(all *_CYC))+1.
  - Ports: load, load value, `zero` flag.
  - Used once by the FSM.
- GO toggle detection stays inline.

Test Plan (SETUP=2, EN=3, HOLD=1, EXEC=5, CLR=20):
- Reset, then toggle GO with RS=1, DATA=0x41 → `lcd_rs`=1 and `lcd_data`=0x41 two cycles before EN. EN high exactly 3 cycles. Busy clears 5 cycles after HOLD. status[15:8]=0x41, count=1.
- Toggle GO with RS=0, DATA=0x01 → WAIT lasts 20 cycles. Repeat with DATA=0x80 → WAIT lasts 5 cycles.
- Toggle GO twice during PULSE, then toggle once more → second request held pending and runs back-to-back with no IDLE cycle. Third request sets overrun=1. count advances by 2. Asserting [11] clears overrun.
- Assert rst=0 mid-PULSE → `lcd_en` drops the same cycle. All status 0. After release, the next GO runs normally.
- Toggle GO in the exact cycle WAIT expires with pending=0 → no transfer lost. SETUP is entered with the new DATA.
- Preload count to 0xFFFF via repeated transfers (or force) → one more transfer wraps count to 0x0000; `lcd_rw` stays 0 throughout.
